// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration among writeback
// requesters plus a sequenced clear that zeroes every register, one per
// cycle, through the same registered write port.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [ADDR_W-1:0]  clr_cnt_q;
    logic               regwrite_q;
    logic [ADDR_W-1:0]  writereg_q;
    logic [DATA_W-1:0]  writedata_q;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;

    // Requester index 'off' positions after 'base', wrapping modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= unsigned'(NUM_REQ)) s = s - unsigned'(NUM_REQ);
        return PTR_W'(s);
    endfunction

    // Round-robin search from rr_ptr; grants are suppressed during reset,
    // while a clear is being requested, and for the whole clear sweep.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
            if (!grant_vld && req_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
        if (reset || clear_req || (state_q != IDLE)) grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // One-hot ready for the winning requester.
    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // Control FSM and registered write port; clear takes priority over
    // pending requests and leaves the round-robin pointer untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            clr_cnt_q   <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clr_cnt_q  <= '0;
                        regwrite_q <= 1'b0;
                    end else if (grant_vld) begin
                        // Address 0 is hardwired: consume the request, no write.
                        regwrite_q  <= (grant_addr != '0);
                        writereg_q  <= grant_addr;
                        writedata_q <= grant_data;
                        rr_ptr_q    <= rr_ptr_d;
                    end else begin
                        regwrite_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    regwrite_q  <= 1'b1;
                    writereg_q  <= clr_cnt_q;
                    writedata_q <= '0;
                    clr_cnt_q   <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q   <= IDLE;
                        clr_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign RegWrite   = regwrite_q;
    assign WriteReg   = writereg_q;
    assign WriteData  = writedata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NUM_REQ=3): each cycle checks the
// combinational grant, then queues the expected write-port contents and
// compares them one edge later.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      clear_req;
    logic                      clear_busy;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         WriteReg;
    logic [DATA_W-1:0]         WriteData;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               sb[$];
    logic [ADDR_W-1:0] held_a;
    logic [DATA_W-1:0] held_d;
    int                ntests = 0;
    int                nfail  = 0;

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic cycle(input logic [NUM_REQ-1:0] exp_rdy, input logic exp_busy,
                         input logic clr_we, input logic [ADDR_W-1:0] clr_a,
                         input string tag);
        wr_t e;
        wr_t got;
        int  g;
        @(negedge clock);
        chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        chk({tag, ".busy"}, 64'(clear_busy), 64'(exp_busy));
        if (reset) begin
            e = '0;
        end else if (exp_rdy != '0) begin
            g    = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
            e.a  = req_addr[g*ADDR_W +: ADDR_W];
            e.d  = req_data[g*DATA_W +: DATA_W];
            e.we = (e.a != '0);
        end else if (clr_we) begin
            e = {1'b1, clr_a, {DATA_W{1'b0}}};
        end else begin
            e = {1'b0, held_a, held_d};
        end
        held_a = e.a;
        held_d = e.d;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({tag, ".RegWrite"}, 64'(RegWrite), 64'(got.we));
        chk({tag, ".WriteReg"}, 64'(WriteReg), 64'(got.a));
        chk({tag, ".WriteData"}, 64'(WriteData), 64'(got.d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        held_a    = '0;
        held_d    = '0;
        reset     = 1'b1;
        clear_req = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 1), 32'hC0DE_0000 + 32'(i));

        // Reset held with all requesters valid: no grants, port cleared.
        cycle(3'b000, 1'b0, 1'b0, '0, "rst0");
        cycle(3'b000, 1'b0, 1'b0, '0, "rst1");
        reset = 1'b0;

        // All valid continuously: grants rotate 0,1,2,0,1,2.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, 5'(i + 1 + 3 * c), 32'hA000_0000 + 32'(c * 16 + i));
            cycle(3'(1 << (c % 3)), 1'b0, 1'b0, '0, $sformatf("rr%0d", c));
        end
        req_valid = 3'b000;
        cycle(3'b000, 1'b0, 1'b0, '0, "rr_idle");

        // Single requester 1 write.
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        cycle(3'b010, 1'b0, 1'b0, '0, "r1");
        req_valid = 3'b000;
        cycle(3'b000, 1'b0, 1'b0, '0, "r1_wr");
        cycle(3'b000, 1'b0, 1'b0, '0, "r1_off");

        // Address 0 write from requester 2: accepted, no RegWrite.
        req_valid = 3'b100;
        set_req(2, 5'd0, 32'h0000_1234);
        cycle(3'b100, 1'b0, 1'b0, '0, "a0");
        req_valid = 3'b111;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(20 + i), 32'hB000_0000 + 32'(i));
        cycle(3'b001, 1'b0, 1'b0, '0, "a0_next");

        // Clear pulse with requester 0 pending: clear wins, then 32 writes.
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_0077);
        clear_req = 1'b1;
        cycle(3'b000, 1'b0, 1'b0, '0, "clr_start");
        clear_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            clear_req = (i == 10);
            cycle(3'b000, 1'b1, 1'b1, 5'(i), $sformatf("clr%0d", i));
        end
        clear_req = 1'b0;
        cycle(3'b001, 1'b0, 1'b0, '0, "clr_after");
        req_valid = 3'b000;
        cycle(3'b000, 1'b0, 1'b0, '0, "clr_req0wr");

        // Reset mid-clear aborts the sweep.
        clear_req = 1'b1;
        cycle(3'b000, 1'b0, 1'b0, '0, "abt_start");
        clear_req = 1'b0;
        for (int i = 0; i <= 10; i++)
            cycle(3'b000, 1'b1, 1'b1, 5'(i), $sformatf("abt%0d", i));
        reset = 1'b1;
        cycle(3'b000, 1'b1, 1'b0, '0, "abt_rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cycle(3'b000, 1'b0, 1'b0, '0, $sformatf("abt_post%0d", i));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
